// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: request/response packet, access type and
// the port id used by the request arbiter.
package mem_pkg;

  typedef enum logic [0:0] {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_type_t;

  typedef struct packed {
    mem_type_t   mtype;
    logic [15:0] addr;
    logic [3:0]  len;
    logic [31:0] data;
  } mem_pkt_t;

  typedef logic mem_port_id_t;

  localparam int MEM_ARB_DEPTH = 4;

endpackage

// File: rtl/mem_owner_fifo.sv
// Synchronous FIFO recording which port owns each outstanding request.
// Push is ignored when full and pop is ignored when empty; no bypass.
module mem_owner_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_ONE   = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_DEPTH);
  assign empty  = (count_r == '0);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = mem_r[rd_ptr_r];

  // Storage, pointers (wrap naturally) and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of memory_model; responses are
// steered back to the issuing port using an in-order owner FIFO.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DEPTH = MEM_ARB_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req0_vld,
  output logic     req0_rdy,
  input  mem_pkt_t req0_pkt,
  input  logic     req1_vld,
  output logic     req1_rdy,
  input  mem_pkt_t req1_pkt,
  output logic     mem_req_vld,
  input  logic     mem_req_rdy,
  output mem_pkt_t mem_req_pkt,
  input  logic     mem_resp_vld,
  output logic     mem_resp_rdy,
  input  mem_pkt_t mem_resp_pkt,
  output logic     resp0_vld,
  input  logic     resp0_rdy,
  output mem_pkt_t resp0_pkt,
  output logic     resp1_vld,
  input  logic     resp1_rdy,
  output mem_pkt_t resp1_pkt
);

  mem_port_id_t grant_s;
  mem_port_id_t last_grant_r;
  mem_port_id_t lock_grant_r;
  logic         lock_r;
  logic         gnt_vld_s;
  logic         push_s;
  logic         pop_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  mem_port_id_t head_s;

  // Grant select: a stalled beat keeps its port, otherwise round-robin
  always_comb begin
    grant_s = 1'b0;
    if (lock_r) begin
      grant_s = lock_grant_r;
    end else if (req0_vld && req1_vld) begin
      grant_s = ~last_grant_r;
    end else if (req1_vld) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign gnt_vld_s   = grant_s ? req1_vld : req0_vld;
  assign mem_req_vld = gnt_vld_s && !fifo_full_s;
  assign mem_req_pkt = grant_s ? req1_pkt : req0_pkt;
  assign req0_rdy    = !grant_s && req0_vld && mem_req_rdy && !fifo_full_s;
  assign req1_rdy    = grant_s && req1_vld && mem_req_rdy && !fifo_full_s;
  assign push_s      = mem_req_vld && mem_req_rdy;

  // Responses go to the owner at the FIFO head; nothing is routed when empty
  assign resp0_vld    = mem_resp_vld && !fifo_empty_s && !head_s;
  assign resp1_vld    = mem_resp_vld && !fifo_empty_s && head_s;
  assign mem_resp_rdy = !fifo_empty_s && (head_s ? resp1_rdy : resp0_rdy);
  assign pop_s        = mem_resp_vld && mem_resp_rdy;
  assign resp0_pkt    = mem_resp_pkt;
  assign resp1_pkt    = mem_resp_pkt;

  // Round-robin history and stall lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      lock_r       <= 1'b0;
      lock_grant_r <= 1'b0;
    end else begin
      lock_r       <= mem_req_vld && !mem_req_rdy;
      lock_grant_r <= grant_s;
      if (push_s) begin
        last_grant_r <= grant_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  mem_owner_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (grant_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  a_resp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_resp_vld && fifo_empty_s));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the bench plays both requesters,
// the memory and both response consumers.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic     clk;
  logic     rst_n;
  logic     req0_vld, req0_rdy, req1_vld, req1_rdy;
  mem_pkt_t req0_pkt, req1_pkt;
  logic     mem_req_vld, mem_req_rdy;
  mem_pkt_t mem_req_pkt;
  logic     mem_resp_vld, mem_resp_rdy;
  mem_pkt_t mem_resp_pkt;
  logic     resp0_vld, resp0_rdy, resp1_vld, resp1_rdy;
  mem_pkt_t resp0_pkt, resp1_pkt;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_vld     (req0_vld),
    .req0_rdy     (req0_rdy),
    .req0_pkt     (req0_pkt),
    .req1_vld     (req1_vld),
    .req1_rdy     (req1_rdy),
    .req1_pkt     (req1_pkt),
    .mem_req_vld  (mem_req_vld),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_pkt  (mem_req_pkt),
    .mem_resp_vld (mem_resp_vld),
    .mem_resp_rdy (mem_resp_rdy),
    .mem_resp_pkt (mem_resp_pkt),
    .resp0_vld    (resp0_vld),
    .resp0_rdy    (resp0_rdy),
    .resp0_pkt    (resp0_pkt),
    .resp1_vld    (resp1_vld),
    .resp1_rdy    (resp1_rdy),
    .resp1_pkt    (resp1_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mem_pkt_t mk(mem_type_t t, logic [15:0] a, logic [31:0] d);
    mem_pkt_t p;
    p.mtype = t;
    p.addr  = a;
    p.len   = 4'd0;
    p.data  = d;
    return p;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input mem_pkt_t obs, input mem_pkt_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_idle(input string tag);
    chk1({tag, "_req0_rdy"}, req0_rdy, 1'b0);
    chk1({tag, "_req1_rdy"}, req1_rdy, 1'b0);
    chk1({tag, "_mem_req_vld"}, mem_req_vld, 1'b0);
    chk1({tag, "_mem_resp_rdy"}, mem_resp_rdy, 1'b0);
    chk1({tag, "_resp0_vld"}, resp0_vld, 1'b0);
    chk1({tag, "_resp1_vld"}, resp1_vld, 1'b0);
  endtask

  mem_pkt_t r2, r4, r6, p0, p1, wr, rd;
  logic     exp_g;

  initial begin
    r2 = mk(READ, 16'h0002, 32'h0000_0000);
    r4 = mk(READ, 16'h0004, 32'h0000_0000);
    r6 = mk(READ, 16'h0006, 32'h0000_0000);
    p0 = mk(READ, 16'h000A, 32'h0000_0000);
    p1 = mk(WRITE, 16'h0008, 32'h0000_55AA);
    wr = mk(WRITE, 16'h0004, 32'hC0FF_EE69);
    rd = mk(READ, 16'h0004, 32'h0000_0000);

    rst_n = 1'b0;
    req0_vld = 1'b0; req1_vld = 1'b0;
    req0_pkt = '0;   req1_pkt = '0;
    mem_req_rdy = 1'b1;
    mem_resp_vld = 1'b0; mem_resp_pkt = '0;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    settle();
    chk_all_idle("reset");
    tick(); tick();
    rst_n = 1'b1;
    settle();
    chk1("post_reset_no_beat", mem_req_vld, 1'b0);

    // Single write from port 0, ack returns on resp0
    req0_pkt = mk(WRITE, 16'h0000, 32'hDEAD_BEEF);
    req0_vld = 1'b1;
    settle();
    chk1("wr_mem_req_vld", mem_req_vld, 1'b1);
    chkp("wr_mem_req_pkt", mem_req_pkt, mk(WRITE, 16'h0000, 32'hDEAD_BEEF));
    chk1("wr_req0_rdy", req0_rdy, 1'b1);
    chk1("wr_req1_rdy", req1_rdy, 1'b0);
    tick();
    req0_vld = 1'b0;
    mem_resp_vld = 1'b1;
    mem_resp_pkt = mk(WRITE, 16'h0000, 32'hDEAD_BEEF);
    settle();
    chk1("wr_ack_resp0_vld", resp0_vld, 1'b1);
    chk1("wr_ack_resp1_vld", resp1_vld, 1'b0);
    chk1("wr_ack_mem_resp_rdy", mem_resp_rdy, 1'b1);
    chkp("wr_ack_resp0_pkt", resp0_pkt, mk(WRITE, 16'h0000, 32'hDEAD_BEEF));
    tick();
    mem_resp_vld = 1'b0;

    // Fresh reset so the first contested cycle goes to port 0
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    tick();

    // Contention: grants alternate 0,1,0,1 and fill the FIFO
    req0_pkt = r2; req1_pkt = r4;
    req0_vld = 1'b1; req1_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      exp_g = k[0];
      chkp("cont_pkt", mem_req_pkt, exp_g ? r4 : r2);
      chk1("cont_req0_rdy", req0_rdy, !exp_g);
      chk1("cont_req1_rdy", req1_rdy, exp_g);
      tick();
    end
    req0_vld = 1'b0; req1_vld = 1'b0;

    // Full: 5th request blocked, even while a pop happens the same cycle
    req0_pkt = r6; req0_vld = 1'b1;
    settle();
    chk1("full_req0_rdy", req0_rdy, 1'b0);
    chk1("full_mem_req_vld", mem_req_vld, 1'b0);
    mem_resp_vld = 1'b1;
    mem_resp_pkt = mk(READ, 16'h0002, 32'h0000_1000);
    settle();
    chk1("full_pop_resp0_vld", resp0_vld, 1'b1);
    chk1("full_pop_resp1_vld", resp1_vld, 1'b0);
    chk1("full_same_cycle_rdy", req0_rdy, 1'b0);
    tick();
    mem_resp_vld = 1'b0;
    settle();
    chk1("full_next_cycle_rdy", req0_rdy, 1'b1);
    chkp("full_next_cycle_pkt", mem_req_pkt, r6);
    tick();
    req0_vld = 1'b0;

    // Response stall: head owner is port 1 (queue 1,0,1,0)
    mem_resp_vld = 1'b1;
    mem_resp_pkt = mk(READ, 16'h0004, 32'h0000_1001);
    resp1_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk1("stall_mem_resp_rdy", mem_resp_rdy, 1'b0);
      chk1("stall_resp0_vld", resp0_vld, 1'b0);
      chk1("stall_resp1_vld", resp1_vld, 1'b1);
      tick();
    end
    resp1_rdy = 1'b1;
    settle();
    chk1("stall_release_rdy", mem_resp_rdy, 1'b1);
    chkp("stall_resp1_pkt", resp1_pkt, mk(READ, 16'h0004, 32'h0000_1001));
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_resp_pkt = mk(READ, 16'h0000, 32'h0000_1002 + k);
      settle();
      exp_g = (k == 1);
      chk1("drain_resp0_vld", resp0_vld, !exp_g);
      chk1("drain_resp1_vld", resp1_vld, exp_g);
      tick();
    end
    mem_resp_vld = 1'b0;
    settle();
    chk1("drain_empty", mem_resp_rdy, 1'b0);

    // Make port 1 the last grant so a non-locked arbiter would pick port 0
    req1_pkt = r4; req1_vld = 1'b1;
    settle();
    chk1("bp_pre_req1_rdy", req1_rdy, 1'b1);
    tick();
    req1_vld = 1'b0;
    mem_resp_vld = 1'b1;
    settle();
    chk1("bp_pre_resp1_vld", resp1_vld, 1'b1);
    tick();
    mem_resp_vld = 1'b0;

    // Backpressure: port 1 granted alone, port 0 joins, grant stays locked
    mem_req_rdy = 1'b0;
    req1_pkt = p1; req1_vld = 1'b1;
    settle();
    chkp("bp_first_pkt", mem_req_pkt, p1);
    tick();
    req0_pkt = p0; req0_vld = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chkp("bp_hold_pkt", mem_req_pkt, p1);
      chk1("bp_hold_vld", mem_req_vld, 1'b1);
      chk1("bp_hold_req0_rdy", req0_rdy, 1'b0);
      chk1("bp_hold_req1_rdy", req1_rdy, 1'b0);
      tick();
    end
    mem_req_rdy = 1'b1;
    settle();
    chkp("bp_accept_pkt", mem_req_pkt, p1);
    chk1("bp_accept_req1_rdy", req1_rdy, 1'b1);
    tick();
    req1_vld = 1'b0;
    settle();
    chkp("bp_next_pkt", mem_req_pkt, p0);
    chk1("bp_next_req0_rdy", req0_rdy, 1'b1);
    tick();
    req0_vld = 1'b0;
    req1_pkt = r4; req1_vld = 1'b1;
    tick();
    req1_vld = 1'b0;

    // Reset mid-flight with 3 outstanding
    #2;
    mem_resp_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_idle("midrst");
    mem_resp_vld = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk1("midrst_no_beat", mem_req_vld, 1'b0);
    chk1("midrst_empty", mem_resp_rdy, 1'b0);

    req1_pkt = wr; req1_vld = 1'b1;
    settle();
    chk1("rw_wr_req1_rdy", req1_rdy, 1'b1);
    chkp("rw_wr_pkt", mem_req_pkt, wr);
    tick();
    req1_vld = 1'b0;
    req0_pkt = rd; req0_vld = 1'b1;
    settle();
    chk1("rw_rd_req0_rdy", req0_rdy, 1'b1);
    chkp("rw_rd_pkt", mem_req_pkt, rd);
    tick();
    req0_vld = 1'b0;
    mem_resp_vld = 1'b1;
    mem_resp_pkt = wr;
    settle();
    chk1("rw_ack_resp1_vld", resp1_vld, 1'b1);
    chk1("rw_ack_resp0_vld", resp0_vld, 1'b0);
    tick();
    mem_resp_pkt = mk(READ, 16'h0004, 32'hC0FF_EE69);
    settle();
    chk1("rw_data_resp0_vld", resp0_vld, 1'b1);
    chk1("rw_data_resp1_vld", resp1_vld, 1'b0);
    chkp("rw_data_pkt", resp0_pkt, mk(READ, 16'h0004, 32'hC0FF_EE69));
    tick();
    mem_resp_vld = 1'b0;
    settle();
    chk1("rw_final_empty", mem_resp_rdy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port request arbiter that sits directly upstream of `memory_model`. It merges the instruction-fetch and data-access packet streams onto the single `mem_pkt_t` request port and returns each response to the port that issued it. Arbitration is round-robin. Response ownership is tracked in an in-order owner FIFO, because `memory_model` answers requests strictly in acceptance order.

## Interface
- `DEPTH` — 4 — maximum outstanding (accepted, not yet answered) requests; power of two, at least 2.
- `clk` input 1 — single clock; all state on rising edge.
- `rst_n` input 1 — reset, asynchronous and active-low.
- `req0_vld` input 1 / `req0_rdy` output 1 / `req0_pkt` input `mem_pkt_t` — port 0 (instruction) request.
- `req1_vld` input 1 / `req1_rdy` output 1 / `req1_pkt` input `mem_pkt_t` — port 1 (data) request.
- `mem_req_vld` output 1 / `mem_req_rdy` input 1 / `mem_req_pkt` output `mem_pkt_t` — to `memory_model` `pkt_in_*`.
- `mem_resp_vld` input 1 / `mem_resp_rdy` output 1 / `mem_resp_pkt` input `mem_pkt_t` — from `memory_model` `pkt_out_*`.
- `resp0_vld` output 1 / `resp0_rdy` input 1 / `resp0_pkt` output `mem_pkt_t` — port 0 response.
- `resp1_vld` output 1 / `resp1_rdy` input 1 / `resp1_pkt` output `mem_pkt_t` — port 1 response.

## Operation
- Transfer rule on every interface: a beat transfers in any cycle where vld and rdy are both 1.
- Packets (`mtype`, `addr`, `len`, `data`) pass through unmodified. The arbiter never interprets `len` or `addr`.
- Response rule: every accepted request, READ or WRITE, produces exactly one response from `memory_model`. A WRITE response is an acknowledge.
- Grant selection:
  - If only one port is valid, that port is granted.
  - If both are valid, the port other than `last_grant` is granted.
  - `last_grant` updates only on an accepted `mem_req` beat.
- Grant lock: if `mem_req_vld` = 1 and `mem_req_rdy` = 0, the same grant and packet are held the next cycle. `mem_req_pkt` must stay stable until accepted.
- Requesters must hold vld and pkt until accepted. The arbiter requires this and does not check it.
- Gating: `mem_req_vld` = granted port's vld AND NOT `fifo_full`.
- Ready return: the granted port's `reqN_rdy` = `mem_req_rdy` AND NOT `fifo_full`. The non-granted port's rdy = 0.
- Owner FIFO: on each accepted `mem_req` beat, the granted port id (1 bit) is pushed.
- Response routing:
  - `mem_resp_pkt` is fanned out to both `respN_pkt`.
  - `respN_vld` = `mem_resp_vld` AND NOT `fifo_empty` AND (head == N).
  - `mem_resp_rdy` = NOT `fifo_empty` AND `resp[head]_rdy`.
  - The FIFO pops on a `mem_resp` handshake.
- Full condition: push is blocked when full, even if a pop occurs in the same cycle. No bypass.
- Simultaneous push and pop when not full: both occur; count unchanged.
- Empty condition: a response arriving while `fifo_empty` is a protocol violation.
  - `mem_resp_rdy` stays 0 and nothing is routed.
  - A simulation assertion fires.
- Pointer wrap: FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Request path is combinational: zero-cycle latency from `reqN_vld` to `mem_req_vld`.
- Response path is combinational: zero-cycle latency from `mem_resp_vld` to `respN_vld`.
- Throughput: one request and one response per cycle concurrently.
- Reset values (asserted `rst_n` = 0, applied immediately):
  - FIFO empty: count 0, pointers 0.
  - `last_grant` = 1, so port 0 wins the first contested cycle.
  - Lock cleared.
  - All `*_vld` and `*_rdy` outputs 0 while in reset, since the FIFO is empty and no port is valid.
- Reset mid-operation discards all outstanding ownership. `memory_model` shares `rst_n` and also flushes.
- Deasserting reset produces no spurious beats.

## Structure
- Shared package (`mem_pkg`, alongside `mem_pkt_t` and the `READ`/`WRITE` enum): `mem_port_id_t` (1-bit port id) and `MEM_ARB_DEPTH` default.
- Sub-module `mem_owner_fifo`: synchronous, parameterised width/depth FIFO.
  - Ports: push, pop, `wdata`, `rdata` (head), full, empty.
  - Owns the pointers and count.
- Top level: round-robin grant logic, lock register, vld/rdy glue, and the empty-response assertion.

## Test plan
- Single write: port 0 sends WRITE addr 0x0, data 0xDEADBEEF, `len` 0, with `mem_req_rdy` = 1.
  - `mem_req_pkt` is identical the same cycle.
  - The ack returns only on `resp0_vld`.
- Contention: both ports are valid for 4 consecutive beats.
  - Port 0 sends READ addr 0x2; port 1 sends READ addr 0x4.
  - Grants alternate 0, 1, 0, 1.
  - Responses are routed to resp0, resp1, resp0, resp1 in order.
- Backpressure hold: `mem_req_rdy` = 0 for 3 cycles while port 1 is granted and port 0 also asserts vld.
  - The grant stays port 1 with a stable pkt.
  - Port 1 is accepted on the first rdy cycle.
- Full: 4 requests issued with responses withheld.
  - The 5th request sees `reqN_rdy` = 0.
  - After one response pops, the 5th is accepted on the following cycle, not the same cycle.
- Response stall: head owner is port 1 and `resp1_rdy` = 0 for 2 cycles.
  - `mem_resp_rdy` = 0 and resp0 stays idle.
  - The response transfers when `resp1_rdy` rises.
- Reset mid-flight: with 3 outstanding, pulse `rst_n` low asynchronously.
  - All vld/rdy outputs go 0 immediately and count is 0.
  - A WRITE to addr 0x4, data 0xC0FFEE69, followed by a READ to 0x4 afterwards returns 0xC0FFEE69 on the correct port.
